// File: rtl/line_follow_ctrl.sv
// Two-sensor line follower: synchronizer, debounce, steering FSM, speed mapping and dual PWM.
// Build option: define SPIN_TURN_EN for pivot turns (inner wheel stopped in TURN_L/TURN_R).
module line_follow_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned PRESCALE        = 1,
    parameter int unsigned LOST_TIMEOUT    = 1024
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       enable,
    input  logic [1:0] sensors,
    input  logic [5:0] speed,
    output logic [5:0] speed_l,
    output logic [5:0] speed_r,
    output logic       pwm_l,
    output logic       pwm_r,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FORWARD = 3'd1,
        TURN_L  = 3'd2,
        TURN_R  = 3'd3,
        SEARCH  = 3'd4,
        STOP    = 3'd5
    } state_t;

    localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] PRE_LAST  = 16'(PRESCALE - 1);
    localparam logic [19:0] LOST_LAST = 20'(LOST_TIMEOUT - 1);

    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    logic [15:0] r_stable_cnt;
    logic [1:0]  r_accepted;
    state_t      r_state;
    state_t      w_next;
    logic [19:0] r_lost;
    logic [5:0]  w_inner;
    logic [5:0]  r_speed_l;
    logic [5:0]  r_speed_r;
    logic [15:0] r_presc;
    logic        w_tick;
    logic [5:0]  r_pwm_cnt;
    logic [5:0]  r_duty_l;
    logic [5:0]  r_duty_r;
    logic        r_pwm_l;
    logic        r_pwm_r;

    // A pending change is visible as sync1 != sync2, so the count restarts on the
    // same edge the new pattern lands in sync2.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_stable_cnt <= '0;
            r_accepted   <= '0;
        end else begin
            r_sync1 <= sensors;
            r_sync2 <= r_sync1;
            if (r_sync1 != r_sync2)
                r_stable_cnt <= '0;
            else if (r_stable_cnt != '1)
                r_stable_cnt <= r_stable_cnt + 16'd1;
            if (r_stable_cnt == DEB_LAST)
                r_accepted <= r_sync2;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!enable) begin
            w_next = IDLE;
        end else if (r_state == IDLE) begin
            w_next = FORWARD;
        end else begin
            case (r_accepted)
                2'b11:   w_next = FORWARD;
                2'b10:   w_next = TURN_L;
                2'b01:   w_next = TURN_R;
                default: begin
                    if (r_state == STOP)
                        w_next = STOP;
                    else if (r_state == SEARCH && r_lost == LOST_LAST)
                        w_next = STOP;
                    else
                        w_next = SEARCH;
                end
            endcase
        end
    end

    // Holding the timer at zero outside SEARCH gives a clean start on every entry.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_lost  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state != SEARCH)
                r_lost <= '0;
            else if (r_lost != LOST_LAST)
                r_lost <= r_lost + 20'd1;
        end
    end

`ifdef SPIN_TURN_EN
    assign w_inner = '0;
`else
    assign w_inner = speed >> 1;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_speed_l <= '0;
            r_speed_r <= '0;
        end else begin
            case (r_state)
                FORWARD: begin r_speed_l <= speed;      r_speed_r <= speed;      end
                TURN_L:  begin r_speed_l <= w_inner;    r_speed_r <= speed;      end
                TURN_R:  begin r_speed_l <= speed;      r_speed_r <= w_inner;    end
                SEARCH:  begin r_speed_l <= speed >> 2; r_speed_r <= speed >> 2; end
                default: begin r_speed_l <= '0;         r_speed_r <= '0;         end
            endcase
        end
    end

    assign w_tick = (r_presc == PRE_LAST);

    // Duty is only refreshed at the 63 -> 0 wrap so a period never changes mid-way.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
            r_duty_l  <= '0;
            r_duty_r  <= '0;
            r_pwm_l   <= 1'b0;
            r_pwm_r   <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 16'd1;
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 6'd1;
                if (r_pwm_cnt == 6'd63) begin
                    r_duty_l <= r_speed_l;
                    r_duty_r <= r_speed_r;
                end
            end
            r_pwm_l <= (r_pwm_cnt < r_duty_l);
            r_pwm_r <= (r_pwm_cnt < r_duty_r);
        end
    end

    assign speed_l = r_speed_l;
    assign speed_r = r_speed_r;
    assign pwm_l   = r_pwm_l;
    assign pwm_r   = r_pwm_r;
    assign state   = r_state;

endmodule
